str_wr_core: RTL and testbench

STR_WR_CORE -- requirements
Module: str_wr_core

---
 rtl/str_wr_core.sv | 187 ++++++++++++++++++
 tb/tb_str_wr_core.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/str_wr_core.sv
// ---------------------------------------------------------------------------
// str_wr_core
// AXI4-Lite register front end that gathers N_PKT 32-bit words into a buffer.
// Once every word has been written since the last beat (or since the last
// software clear), the buffer is presented as one packed beat on a
// valid/ready stream.  It is held stable until the beat is accepted.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET    clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*/AR*/R*      AXI4-Lite slave (responses always OKAY)
//   m_tdata/m_tvalid/m_tready   packed output beat, word k at [32k+31:32k]
//   busy                        high while a beat is pending on the stream
//   write_data_count,
//   read_data_count             downstream FIFO levels, readable at 0x00/0x04
//
// Register map (word index = addr[7:2])
//   0x00 write_data_count RO    0x04 read_data_count RO
//   0x08 word_written RO        0x0C rd: pkt_count, wr: bit0=1 clears word_written
//   0x10+4k data word k R/W
// ---------------------------------------------------------------------------
module str_wr_core #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int N_PKT              = 3
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*N_PKT-1:0]             m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            busy,
    input  logic [31:0]                     write_data_count,
    input  logic [31:0]                     read_data_count
);

    // state | meaning
    // FILL  | collecting words from AXI writes, stream idle
    // SEND  | beat presented on the stream, buffer frozen
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [IW-1:0] IDX_WDC  = IW'(0);
    localparam logic [IW-1:0] IDX_RDC  = IW'(1);
    localparam logic [IW-1:0] IDX_WW   = IW'(2);
    localparam logic [IW-1:0] IDX_CTRL = IW'(3);

    logic [0:0]       state_q, state_d;
    logic [31:0]      pkt_buf_q [N_PKT];
    logic [31:0]      pkt_buf_d [N_PKT];
    logic [N_PKT-1:0] ww_q, ww_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;

    logic             awready_q, bvalid_q;
    logic             arready_q, rvalid_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rd_data;

    logic             wr_en, rd_en;
    logic [IW-1:0]    aw_idx, ar_idx;

    assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // AWREADY/WREADY are one shared register; the write lands in the cycle
    // it is high, so the address and data are taken straight off the bus.
    assign wr_en = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en = arready_q && S_AXI_ARVALID;

    always_comb begin
        rd_data = '0;
        case (ar_idx)
            IDX_WDC:  rd_data = write_data_count;
            IDX_RDC:  rd_data = read_data_count;
            IDX_WW:   rd_data = 32'(ww_q);
            IDX_CTRL: rd_data = pkt_cnt_q;
            default:  rd_data = '0;
        endcase
        for (int k = 0; k < N_PKT; k++) begin
            if (ar_idx == IW'(4 + k)) rd_data = pkt_buf_q[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        ww_d      = ww_q;
        pkt_cnt_d = pkt_cnt_q;
        for (int k = 0; k < N_PKT; k++) pkt_buf_d[k] = pkt_buf_q[k];

        if (state_q == ST_FILL) begin
            if (wr_en) begin
                for (int k = 0; k < N_PKT; k++) begin
                    if (aw_idx == IW'(4 + k)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (S_AXI_WSTRB[b]) pkt_buf_d[k][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                        end
                        ww_d[k] = 1'b1;
                    end
                end
                if (aw_idx == IDX_CTRL && S_AXI_WDATA[0]) ww_d = '0;
                // Go straight to SEND on the edge that completes the set.
                if (&ww_d) state_d = ST_SEND;
            end
        end else begin
            // AXI writes still complete in SEND but touch nothing here.
            if (m_tready) begin
                state_d   = ST_FILL;
                ww_d      = '0;
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q   <= ST_FILL;
            ww_q      <= '0;
            pkt_cnt_q <= '0;
            for (int k = 0; k < N_PKT; k++) pkt_buf_q[k] <= '0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ww_q      <= ww_d;
            pkt_cnt_q <= pkt_cnt_d;
            for (int k = 0; k < N_PKT; k++) pkt_buf_q[k] <= pkt_buf_d[k];

            awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
            if (wr_en)
                bvalid_q <= 1'b1;
            else if (S_AXI_BREADY)
                bvalid_q <= 1'b0;

            arready_q <= !arready_q && S_AXI_ARVALID && !rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        m_tdata = '0;
        for (int k = 0; k < N_PKT; k++) m_tdata[32*k +: 32] = pkt_buf_q[k];
    end

    assign m_tvalid      = (state_q == ST_SEND);
    assign busy          = m_tvalid;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_str_wr_core.sv
module tb_str_wr_core;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [32*N-1:0] m_tdata;
    logic        m_tvalid, m_tready, busy;
    logic [31:0] wdc, rdc;

    str_wr_core #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .N_PKT(N)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy),
        .write_data_count(wdc), .read_data_count(rdc)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: word buffer, set of written words, beat counter, beat pending.
    logic [31:0] m_buf [N];
    logic [N-1:0] m_ww;
    logic [31:0] m_pkt;
    bit m_send;

    logic [31:0]     exp_r_q [$];
    logic [32*N-1:0] exp_beat_q [$];
    int              b_pending = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [32*N-1:0] model_beat();
        logic [32*N-1:0] b;
        for (int k = 0; k < N; k++) b[32*k +: 32] = m_buf[k];
        return b;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int idx;
        idx = int'(a) / 4;
        if (idx == 0) return wdc;
        if (idx == 1) return rdc;
        if (idx == 2) return 32'(m_ww);
        if (idx == 3) return m_pkt;
        if (idx >= 4 && idx < 4 + N) return m_buf[idx - 4];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        if (m_send) return;
        if (idx >= 4 && idx < 4 + N) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_buf[idx - 4][8*b +: 8] = d[8*b +: 8];
            m_ww[idx - 4] = 1'b1;
            if (m_ww == {N{1'b1}}) m_send = 1;
        end else if (idx == 3 && d[0]) begin
            m_ww = '0;
        end
    endtask

    task automatic model_accept();
        if (m_send) begin
            m_send = 0;
            m_ww   = '0;
            m_pkt  = m_pkt + 1;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_buf[k] = '0;
        m_ww = '0; m_pkt = '0; m_send = 0;
    endtask

    // Monitor: randomizes the response-channel ready lines and scores every
    // handshake against the expectation queues.
    initial begin
        forever begin
            @(negedge clk);
            RREADY = ($urandom_range(0, 3) != 0);
            BREADY = ($urandom_range(0, 3) != 0);
            if (!rst) begin
                if (RVALID && RREADY) begin
                    if (exp_r_q.size() == 0) begin
                        check("unexpected_rvalid", 1'b1, 1'b0);
                    end else begin
                        check("rdata", RDATA, exp_r_q.pop_front());
                        check("rresp", RRESP, 2'b00);
                    end
                end
                if (BVALID && BREADY) begin
                    if (b_pending == 0) check("unexpected_bvalid", 1'b1, 1'b0);
                    else begin
                        b_pending--;
                        check("bresp", BRESP, 2'b00);
                    end
                end
                if (m_tvalid && m_tready) begin
                    if (exp_beat_q.size() == 0) check("unexpected_beat", 1'b1, 1'b0);
                    else check("beat_tdata", m_tdata, exp_beat_q.pop_front());
                end
            end
        end
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        @(negedge clk);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
        b_pending++;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (AWREADY) begin ok = 1; break; end
        end
        if (!ok) begin
            check("awready_timeout", 1'b0, 1'b1);
            AWVALID = 0; WVALID = 0;
            return;
        end
        check("wready_with_awready", WREADY, 1'b1);
        @(posedge clk); #1;
        AWVALID = 0; WVALID = 0;
        model_write(a, d, s);
        check("awready_one_cycle", AWREADY, 1'b0);
        check("bvalid_after_wr", BVALID, 1'b1);
        check("tvalid_after_wr", m_tvalid, m_send);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (b_pending == 0 && !BVALID) begin ok = 1; break; end
        end
        if (!ok) check("bresp_timeout", 1'b0, 1'b1);
    endtask

    task automatic axi_read(input logic [7:0] a, input bit pulse_rdy);
        bit ok = 0;
        @(negedge clk);
        exp_r_q.push_back(model_read(a));
        ARADDR = a; ARVALID = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (ARREADY) begin ok = 1; break; end
        end
        if (!ok) begin
            check("arready_timeout", 1'b0, 1'b1);
            ARVALID = 0;
            return;
        end
        // Optionally accept a beat on the very edge the read data is captured.
        if (pulse_rdy) begin
            if (m_send) exp_beat_q.push_back(model_beat());
            m_tready = 1;
        end
        @(posedge clk); #1;
        ARVALID = 0;
        if (pulse_rdy) begin
            m_tready = 0;
            model_accept();
        end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (exp_r_q.size() == 0 && !RVALID) begin ok = 1; break; end
        end
        if (!ok) check("rvalid_timeout", 1'b0, 1'b1);
    endtask

    task automatic pulse_tready();
        @(posedge clk); #1;
        if (m_send) exp_beat_q.push_back(model_beat());
        m_tready = 1;
        @(posedge clk); #1;
        m_tready = 0;
        model_accept();
        check("tvalid_after_accept", m_tvalid, m_send);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_tvalid"}, m_tvalid, m_send);
        check({tag, "_busy"}, busy, m_send);
        if (m_send) check({tag, "_tdata"}, m_tdata, model_beat());
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  a;
        int op;

        rst = 1; m_tready = 0;
        AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
        ARADDR = 0; ARPROT = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
        wdc = 32'h0; rdc = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("rst_valids", {BVALID, RVALID}, 2'b00);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_resps", {BRESP, RRESP}, 4'h0);
        check("rst_tdata", m_tdata, '0);
        @(negedge clk); rst = 0;

        // Fill three words; beat appears one cycle after the last write enable.
        axi_write(8'h10, 32'h11111111, 4'hF);
        axi_write(8'h14, 32'h22222222, 4'hF);
        axi_write(8'h18, 32'h33333333, 4'hF);
        check("beat_literal", m_tdata, 96'h333333332222222211111111);
        check("busy_in_send", busy, 1'b1);
        axi_read(8'h08, 0);

        // Writes during SEND complete but change nothing.
        axi_write(8'h10, 32'hDEADBEEF, 4'hF);
        check("tdata_frozen", m_tdata, 96'h333333332222222211111111);
        axi_write(8'h0C, 32'h1, 4'hF);
        check_stream("send_clear_ignored");
        axi_read(8'h10, 0);
        axi_read(8'h08, 0);

        pulse_tready();
        axi_read(8'h08, 0);
        axi_read(8'h0C, 0);

        // A clear in the middle of filling means word 2 alone does not send.
        axi_write(8'h10, 32'h11111111, 4'hF);
        axi_write(8'h14, 32'h55555555, 4'hF);
        axi_write(8'h0C, 32'h1, 4'hF);
        axi_write(8'h18, 32'h66666666, 4'hF);
        check_stream("after_clear");
        axi_read(8'h08, 0);
        axi_read(8'h0C, 0);

        // Byte strobes, unmapped read/write, RO write.
        axi_write(8'h10, 32'h000000AB, 4'h1);
        axi_read(8'h10, 0);
        axi_read(8'h40, 0);
        axi_write(8'h40, 32'hFFFFFFFF, 4'hF);
        axi_write(8'h08, 32'hFFFFFFFF, 4'hF);
        axi_read(8'h08, 0);
        check_stream("after_ro_write");

        // Read pkt_count on the same edge the beat is accepted: old value.
        axi_write(8'h10, 32'hA0A0A0A0, 4'hF);
        axi_write(8'h14, 32'hB1B1B1B1, 4'hF);
        check_stream("second_beat");
        axi_read(8'h0C, 1);
        axi_read(8'h0C, 0);
        axi_read(8'h08, 0);

        // Reset in SEND with m_tready high: beat dropped, not counted.
        axi_write(8'h10, 32'h01020304, 4'hF);
        axi_write(8'h14, 32'h05060708, 4'hF);
        axi_write(8'h18, 32'h090A0B0C, 4'hF);
        check_stream("pre_reset");
        @(posedge clk); #1;
        rst = 1; m_tready = 1;
        @(posedge clk); #1;
        check("tvalid_dropped_by_rst", m_tvalid, 1'b0);
        m_tready = 0;
        @(negedge clk); rst = 0;
        model_reset();
        axi_read(8'h08, 0);
        axi_read(8'h0C, 0);
        axi_read(8'h10, 0);
        wdc = 32'h1234;
        axi_read(8'h00, 0);

        // Randomized mix checked against the model.
        for (int n = 0; n < 120; n++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            if (op <= 3) begin
                a = 8'(16 + 4 * $urandom_range(0, N - 1));
                axi_write(a, d, 4'($urandom_range(0, 15)));
            end else if (op == 4) begin
                axi_write(8'h0C, d, 4'hF);
            end else if (op == 5) begin
                a = 8'($urandom_range(0, 63) * 4);
                if (a >= 8'h0C && a < 8'(16 + 4 * N)) a = 8'h08;
                axi_write(a, d, 4'hF);
            end else if (op <= 7) begin
                axi_read(8'($urandom_range(0, 17) * 4), 0);
            end else if (op == 8) begin
                if ($urandom_range(0, 1) == 1) axi_read(8'h0C, 1);
                else pulse_tready();
            end else begin
                wdc = $urandom; rdc = $urandom;
                axi_read(8'($urandom_range(0, 1) * 4), 0);
            end
            check_stream("rand");
        end

        repeat (5) @(posedge clk);
        #1;
        check("leftover_reads", 32'(exp_r_q.size()), 32'h0);
        check("leftover_beats", 32'(exp_beat_q.size()), 32'h0);
        check("leftover_bresp", 32'(b_pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
